// File: rtl/kugelblitz_tx_min_pad_pkg.sv
// Shared constants and helpers for the QSFP TX minimum-length pad stage.
package kugelblitz_tx_min_pad_pkg;

    localparam int KB_DATA_WIDTH    = 512;
    localparam int KB_KEEP_WIDTH    = KB_DATA_WIDTH / 8;
    localparam int KB_MIN_FRAME_LEN = 60;
    localparam int KB_TUSER_ERR_BIT = 0;
    localparam int KB_STAT_WIDTH    = 32;

    // Lane count 0..64 needs 7 bits
    typedef logic [6:0] kb_lane_cnt_t;

    function automatic kb_lane_cnt_t kb_popcount(input logic [KB_KEEP_WIDTH-1:0] keep);
        kb_lane_cnt_t n;
        n = '0;
        for (int unsigned i = 0; i < KB_KEEP_WIDTH; i++) begin
            n = n + kb_lane_cnt_t'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/kugelblitz_tx_min_pad_if.sv
// AXI-Stream bundle used on both sides of the TX pad stage.
interface kugelblitz_tx_min_pad_if
    import kugelblitz_tx_min_pad_pkg::*;
#(
    parameter int DATA_WIDTH = KB_DATA_WIDTH,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/kugelblitz_axis_skid.sv
// Register slice with one skid entry; upstream ready is registered and
// never depends combinationally on downstream ready.
module kugelblitz_axis_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_fire, out_fire;

    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        in_fire      = in_valid & in_ready_q;
        out_fire     = out_valid_q & out_ready;
        // Skid is only ever occupied while in_ready_q is low, so it cannot collide with in_fire
        if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q   <= '0;
            skid_data_q  <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule

// File: rtl/kugelblitz_tx_min_pad.sv
// Pads single-beat frames shorter than MIN_FRAME_LEN with zero bytes ahead of
// the CMAC TX input, registers the stream and keeps per-port statistics.
module kugelblitz_tx_min_pad
    import kugelblitz_tx_min_pad_pkg::*;
#(
    parameter int DATA_WIDTH    = KB_DATA_WIDTH,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 1,
    parameter int MIN_FRAME_LEN = KB_MIN_FRAME_LEN,
    parameter int STAT_WIDTH    = KB_STAT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    kugelblitz_tx_min_pad_if.slave    s_axis,
    kugelblitz_tx_min_pad_if.master   m_axis,
    output logic [STAT_WIDTH-1:0]     stat_frames,
    output logic [STAT_WIDTH-1:0]     stat_bytes,
    output logic [STAT_WIDTH-1:0]     stat_padded,
    output logic [STAT_WIDTH-1:0]     stat_err
);
    localparam int           PAYLOAD_W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 2;
    localparam kb_lane_cnt_t MIN_LEN   = kb_lane_cnt_t'(MIN_FRAME_LEN);

    if (DATA_WIDTH != 512 || KEEP_WIDTH * 8 != DATA_WIDTH ||
        MIN_FRAME_LEN < 1 || MIN_FRAME_LEN > KEEP_WIDTH) begin : g_bad_cfg
        $error("kugelblitz_tx_min_pad: illegal DATA_WIDTH/KEEP_WIDTH/MIN_FRAME_LEN");
    end

    logic                  first_beat_q, first_beat_d;
    logic                  s_fire, m_fire, pad;
    kb_lane_cnt_t          in_cnt, out_cnt;
    logic [KEEP_WIDTH-1:0] min_mask, pad_keep;
    logic [DATA_WIDTH-1:0] pad_data;
    logic [PAYLOAD_W-1:0]  out_payload;
    logic                  out_pad;
    logic [STAT_WIDTH-1:0] frames_q, frames_d, bytes_q, bytes_d;
    logic [STAT_WIDTH-1:0] padded_q, padded_d, err_q, err_d;

    always_comb begin
        min_mask = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            min_mask[i] = (int'(i) < MIN_FRAME_LEN);
        end
        s_fire   = s_axis.tvalid & s_axis.tready;
        in_cnt   = kb_popcount(s_axis.tkeep);
        pad      = first_beat_q & s_axis.tlast & (in_cnt < MIN_LEN);
        pad_keep = s_axis.tkeep;
        pad_data = s_axis.tdata;
        if (pad) begin
            pad_keep = s_axis.tkeep | min_mask;
            for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
                if (min_mask[i] && !s_axis.tkeep[i]) pad_data[8*i +: 8] = '0;
            end
        end
        first_beat_d = first_beat_q;
        if (s_fire) first_beat_d = s_axis.tlast;
    end

    // Padded flag rides in the slice so statistics are taken at the output handshake
    kugelblitz_axis_skid #(.WIDTH(PAYLOAD_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_axis.tvalid),
        .in_ready  (s_axis.tready),
        .in_data   ({pad, s_axis.tuser, s_axis.tlast, pad_keep, pad_data}),
        .out_valid (m_axis.tvalid),
        .out_ready (m_axis.tready),
        .out_data  (out_payload)
    );

    assign {out_pad, m_axis.tuser, m_axis.tlast, m_axis.tkeep, m_axis.tdata} = out_payload;

    always_comb begin
        m_fire   = m_axis.tvalid & m_axis.tready;
        out_cnt  = kb_popcount(m_axis.tkeep);
        frames_d = frames_q;
        bytes_d  = bytes_q;
        padded_d = padded_q;
        err_d    = err_q;
        if (m_fire) begin
            frames_d = frames_q + STAT_WIDTH'(m_axis.tlast);
            bytes_d  = bytes_q + STAT_WIDTH'(out_cnt);
            padded_d = padded_q + STAT_WIDTH'(out_pad);
            err_d    = err_q + STAT_WIDTH'(m_axis.tlast & m_axis.tuser[KB_TUSER_ERR_BIT]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_beat_q <= 1'b1;
            frames_q     <= '0;
            bytes_q      <= '0;
            padded_q     <= '0;
            err_q        <= '0;
        end else begin
            first_beat_q <= first_beat_d;
            frames_q     <= frames_d;
            bytes_q      <= bytes_d;
            padded_q     <= padded_d;
            err_q        <= err_d;
        end
    end

    assign stat_frames = frames_q;
    assign stat_bytes  = bytes_q;
    assign stat_padded = padded_q;
    assign stat_err    = err_q;
endmodule

// File: tb/tb_kugelblitz_tx_min_pad.sv
// Randomised and directed bench for the TX minimum-length pad stage with a
// frame-level reference model and output scoreboard.
module tb_kugelblitz_tx_min_pad;
    localparam int DW = 512;
    localparam int KW = 64;
    localparam int UW = 1;
    localparam int SW = 32;
    localparam int MINLEN = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kugelblitz_tx_min_pad_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_if ();
    kugelblitz_tx_min_pad_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_if ();

    logic [SW-1:0] stat_frames, stat_bytes, stat_padded, stat_err;

    kugelblitz_tx_min_pad #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
        .MIN_FRAME_LEN(MINLEN), .STAT_WIDTH(SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .stat_frames (stat_frames),
        .stat_bytes  (stat_bytes),
        .stat_padded (stat_padded),
        .stat_err    (stat_err)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
        bit            padded;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned m_frames, m_bytes, m_padded, m_err;
    bit          mid_frame;
    bit          rand_ready = 1'b0;
    bit          fixed_ready = 1'b1;
    bit          track_low = 1'b0;
    int          low_run = 0;
    int          max_low_run = 0;

    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int count_lanes(input logic [KW-1:0] keep);
        int n = 0;
        for (int i = 0; i < KW; i++) n += int'(keep[i]);
        return n;
    endfunction

    // Frame-level view: a frame that fits in one beat and is shorter than MINLEN
    // bytes becomes exactly MINLEN bytes, the tail filled with zeros.
    function automatic beat_t model_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                         input logic l, input logic [UW-1:0] u, input bit mid);
        beat_t b;
        int    len;
        len      = count_lanes(k);
        b.data   = d;
        b.keep   = k;
        b.last   = l;
        b.user   = u;
        b.padded = (!mid && l && len < MINLEN);
        if (b.padded) begin
            for (int i = 0; i < KW; i++) begin
                b.keep[i] = (i < MINLEN);
                if (i >= len) b.data[8*i +: 8] = 8'h00;
            end
        end
        return b;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (s_if.tvalid && s_if.tready) begin
                exp_q.push_back(model_beat(s_if.tdata, s_if.tkeep, s_if.tlast, s_if.tuser, mid_frame));
                mid_frame = !s_if.tlast;
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat", {m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata},
                          {e.user, e.last, e.keep, e.data});
                    m_frames += e.last;
                    m_bytes  += count_lanes(e.keep);
                    m_padded += e.padded;
                    m_err    += (e.last && e.user[0]);
                end
            end
            if (track_low) begin
                low_run = s_if.tready ? 0 : low_run + 1;
                if (low_run > max_low_run) max_low_run = low_run;
            end
        end
    end

    // Downstream ready: fixed level or random with stalls never longer than one cycle
    initial begin
        bit prev_low = 1'b0;
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_if.tready = prev_low ? 1'b1 : 1'($urandom_range(0, 1));
            else            m_if.tready = fixed_ready;
            prev_low = !m_if.tready;
        end
    end

    task automatic clear_model();
        exp_q.delete();
        m_frames  = 0;
        m_bytes   = 0;
        m_padded  = 0;
        m_err     = 0;
        mid_frame = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_s_tready", s_if.tready, 0);
        check("rst_m_tkeep", m_if.tkeep, 0);
        check("rst_stat_frames", stat_frames, 0);
        check("rst_stat_bytes", stat_bytes, 0);
        rst = 1'b0;
        #1;
        check("release_tready_low", s_if.tready, 0);
        @(posedge clk);
        #1;
        check("release_tready_high", s_if.tready, 1);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input logic [UW-1:0] u);
        bit acc;
        int n = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tuser  = u;
        s_if.tvalid = 1'b1;
        do begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 0, 1);
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check("drain_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats();
        check("stat_frames", stat_frames, m_frames);
        check("stat_bytes", stat_bytes, m_bytes);
        check("stat_padded", stat_padded, m_padded);
        check("stat_err", stat_err, m_err);
    endtask

    function automatic logic [DW-1:0] rand_data(input int len);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom();
        for (int i = 0; i < KW; i++) if (i >= len) d[8*i +: 8] = 8'h00;
        return d;
    endfunction

    function automatic logic [KW-1:0] lanes(input int len);
        logic [KW-1:0] k;
        for (int i = 0; i < KW; i++) k[i] = (i < len);
        return k;
    endfunction

    initial begin
        logic [DW-1:0] d;
        s_if.tvalid = 1'b0;

        // 16-byte frame of 0xAA padded to 60
        fixed_ready = 1'b1;
        apply_reset();
        d = '0;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'hAA;
        send_beat(d, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0);
        check("t1_tkeep", m_if.tkeep, 64'h0FFF_FFFF_FFFF_FFFF);
        check("t1_tdata", m_if.tdata, d);
        drain();
        check_stats();
        check("t1_padded", stat_padded, 1);
        check("t1_bytes", stat_bytes, 60);

        // Full 64-byte frame, unchanged, one cycle latency
        apply_reset();
        d = rand_data(64);
        send_beat(d, '1, 1'b1, 1'b0);
        check("t2_latency_valid", m_if.tvalid, 1);
        check("t2_tdata", m_if.tdata, d);
        drain();
        check_stats();
        check("t2_padded", stat_padded, 0);
        check("t2_bytes", stat_bytes, 64);

        // 3-beat frame whose last beat carries 1 byte: never padded
        apply_reset();
        send_beat(rand_data(64), '1, 1'b0, 1'b0);
        send_beat(rand_data(64), '1, 1'b0, 1'b0);
        send_beat(rand_data(1), 64'h1, 1'b1, 1'b0);
        drain();
        check_stats();
        check("t3_bytes", stat_bytes, 129);
        check("t3_frames", stat_frames, 1);
        check("t3_padded", stat_padded, 0);

        // 1000 back-to-back single-beat frames under random backpressure
        apply_reset();
        rand_ready  = 1'b1;
        max_low_run = 0;
        low_run     = 0;
        track_low   = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            int len = int'($urandom_range(0, 64));
            send_beat(rand_data(len), lanes(len), 1'b1, 1'($urandom_range(0, 1)));
        end
        track_low  = 1'b0;
        rand_ready = 1'b0;
        drain();
        check_stats();
        check("t4_frames", stat_frames, 1000);
        check("t4_max_tready_low", max_low_run <= 1, 1);

        // Empty errored frame becomes 60 zero bytes with tuser kept
        apply_reset();
        send_beat('0, '0, 1'b1, 1'b1);
        drain();
        check_stats();
        check("t5_err", stat_err, 1);
        check("t5_padded", stat_padded, 1);
        check("t5_bytes", stat_bytes, 60);

        // Reset in the middle of a stalled 3-beat frame
        fixed_ready = 1'b0;
        apply_reset();
        send_beat(rand_data(64), '1, 1'b0, 1'b0);
        send_beat(rand_data(64), '1, 1'b0, 1'b0);
        s_if.tdata  = rand_data(64);
        s_if.tkeep  = '1;
        s_if.tvalid = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_tvalid", m_if.tvalid, 0);
        fixed_ready = 1'b1;
        apply_reset();
        send_beat(rand_data(20), lanes(20), 1'b1, 1'b0);
        drain();
        check_stats();
        check("t6_frames", stat_frames, 1);
        check("t6_padded", stat_padded, 1);
        check("t6_bytes", stat_bytes, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
